// File: rtl/fork_pkg.sv
// Shared definitions for the fork_n_sync 4-phase fork: FSM encoding and branch-count limits.
package fork_pkg;

  localparam int unsigned N_OUT_MIN = 2;
  localparam int unsigned N_OUT_MAX = 16;

  localparam int unsigned SYNC_NONE = 0;
  localparam int unsigned SYNC_TWO  = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_ACK      = 2'd3
  } fork_state_e;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchroniser for a single asynchronous level, async active-low reset.
module sync_ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/fork_n_sync.sv
// 4-phase handshake fork: one input transaction is broadcast to the enabled branches,
// each released independently, and the input is acknowledged once every branch returned to zero.
module fork_n_sync
  import fork_pkg::*;
#(
  parameter int unsigned N_OUT       = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_in_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic [N_OUT-1:0]  en_mask_i,
  output logic              ack_in_o,
  output logic [N_OUT-1:0]  req_out_o,
  output logic [DATA_W-1:0] data_out_o,
  input  logic [N_OUT-1:0]  ack_out_i,
  output logic              busy_o,
  output logic              err_o
);

  if ((N_OUT < N_OUT_MIN) || (N_OUT > N_OUT_MAX)) begin : g_bad_n_out
    $error("fork_n_sync: N_OUT out of range");
  end
  if ((SYNC_STAGES != SYNC_NONE) && (SYNC_STAGES != SYNC_TWO)) begin : g_bad_sync
    $error("fork_n_sync: SYNC_STAGES must be 0 or 2");
  end

  logic [N_OUT-1:0] w_ack_s;

  // Branch acknowledges may come from another clock domain.
  if (SYNC_STAGES == SYNC_TWO) begin : g_sync
    for (genvar k = 0; k < N_OUT; k++) begin : g_bit
      sync_ff u_sync_ff (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ack_out_i[k]),
        .q_o    (w_ack_s[k])
      );
    end
  end else begin : g_nosync
    assign w_ack_s = ack_out_i;
  end

  fork_state_e       r_state;
  fork_state_e       w_state_nxt;
  logic [N_OUT-1:0]  r_pending;
  logic [N_OUT-1:0]  w_pending_nxt;
  logic [N_OUT-1:0]  r_mask;
  logic [N_OUT-1:0]  w_mask_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic [N_OUT-1:0]  r_req_out;
  logic              r_ack_in;
  logic              r_busy;
  logic              r_err;
  logic              w_viol;
  logic [N_OUT-1:0]  w_pending_rel;

  assign w_pending_rel = r_pending & ~w_ack_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      r_req_out <= '0;
      r_ack_in  <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_mask    <= w_mask_nxt;
      r_data    <= w_data_nxt;
      r_req_out <= r_pending;
      r_ack_in  <= (w_state_nxt == ST_ACK);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_err     <= r_err | w_viol;
    end
  end

  // Next-state, capture and protocol-violation detection.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_mask_nxt    = r_mask;
    w_data_nxt    = r_data;
    w_viol        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_viol = |w_ack_s;
        if (req_in_i) begin
          w_data_nxt    = data_in_i;
          w_mask_nxt    = en_mask_i;
          w_pending_nxt = en_mask_i;
          w_state_nxt   = (en_mask_i == '0) ? ST_ACK : ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        w_viol        = |(w_ack_s & ~r_mask);
        w_pending_nxt = w_pending_rel;
        if (w_pending_rel == '0) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_viol = |(w_ack_s & ~r_mask);
        if ((w_ack_s & r_mask) == '0) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_viol = |(w_ack_s & ~r_mask);
        if (!req_in_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack_in_o   = r_ack_in;
  assign req_out_o  = r_req_out;
  assign data_out_o = r_data;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule

// File: doc/fork_n_sync.md
FORK_N_SYNC -- requirements
Module: fork_n_sync

Interface
REQ-001 Parameter N_OUT, default 3, number of output branches, legal 2..16.
REQ-002 Parameter DATA_W, default 32, width of bundled data.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser flops per ack_out_i bit, legal 0 or 2.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 req_in_i  in  1  4-phase input request.
REQ-007 data_in_i  in  DATA_W  bundled data, stable while req_in_i high.
REQ-008 en_mask_i  in  N_OUT  branches to serve, sampled with data.
REQ-009 ack_in_o  out  1  4-phase input acknowledge.
REQ-010 req_out_o  out  N_OUT  per-branch 4-phase request.
REQ-011 data_out_o  out  DATA_W  captured data, common to all branches.
REQ-012 ack_out_i  in  N_OUT  per-branch acknowledge, possibly asynchronous.
REQ-013 busy_o  out  1  high in any state except IDLE.
REQ-014 err_o  out  1  sticky protocol-violation flag.

Function
REQ-015 All outputs SHALL be registered; ack_out_i SHALL pass SYNC_STAGES flops before use (ack_s).
REQ-016 FSM SHALL have states IDLE, DISPATCH, DRAIN, ACK.
REQ-017 IDLE: on req_in_i=1, capture data_in_i and en_mask_i, set pending=en_mask_i; next state DISPATCH, or ACK if en_mask_i=0.
REQ-018 req_out_o[k] SHALL equal pending[k] registered; rises one cycle after capture edge.
REQ-019 DISPATCH: pending[k] SHALL clear on the edge where ack_s[k]=1; branches release independently (eager fork).
REQ-020 DISPATCH SHALL exit to DRAIN when pending is all zero.
REQ-021 DRAIN SHALL wait until (ack_s & mask)=0, then go to ACK; if already zero on entry, ACK next cycle.
REQ-022 ACK: ack_in_o=1; when req_in_i=0, go to IDLE, ack_in_o=0 next cycle.
REQ-023 New capture SHALL occur only in IDLE; req_in_i high in IDLE immediately after ACK is a new transaction.
REQ-024 data_out_o SHALL hold captured value until next capture.
REQ-025 err_o SHALL set on the cycle ack_s[k]=1 for a branch with mask[k]=0 while busy, or any ack_s in IDLE; cleared only by reset.
REQ-026 Simultaneous acks from several branches SHALL clear all corresponding pending bits in one cycle.
REQ-027 Latency, SYNC_STAGES=0, all acks in the cycle after req_out: req_in_i to ack_in_o at least 4 cycles.

Reset
REQ-028 rst_ni low SHALL asynchronously force FSM=IDLE, pending=0, mask=0, data_out_o=0, req_out_o=0, ack_in_o=0, busy_o=0, err_o=0, synchronisers=0.
REQ-029 Reset mid-transaction SHALL abandon it; after release, req_in_i still high starts a fresh capture.

Structure
REQ-030 Package fork_pkg SHALL hold the FSM state enum and N_OUT limit constants.
REQ-031 One sub-module, sync_ff (2-flop synchroniser, async active-low reset), SHALL be instantiated per ack bit when SYNC_STAGES=2.

Verification (N_OUT=3, DATA_W=8, SYNC_STAGES=0)
REQ-032 Full fork: data 0xA5, mask 3'b111, acks high one cycle after req_out -> req_out_o 3'b111 then 3'b000, data_out_o=0xA5, ack_in_o high, err_o=0.
REQ-033 Staggered acks: branch0 at +1, branch2 at +5, branch1 at +9 cycles -> each req_out_o bit drops individually, ack_in_o waits for last ack low.
REQ-034 Partial mask 3'b101 -> req_out_o[1] never rises; ack_out_i[1] pulsed -> err_o=1 and stays 1.
REQ-035 Mask 3'b000 -> no req_out_o, ack_in_o high on next cycle after capture, data_out_o updated.
REQ-036 rst_ni low in DISPATCH with req_out_o=3'b011 -> all outputs 0 immediately; req_in_i held high -> new capture after release.
REQ-037 Back-to-back: req_in_i rises the cycle after ack_in_o falls -> second transaction captured correctly, no lost or duplicated req_out_o pulse.
